// File: rtl/core_pkg.sv
// Shared constants and types for the load/store pipeline stage:
// opcodes, access-size selectors, the stage FSM encoding and an access
// legality/alignment helper.
package core_pkg;

   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } mem_state_e;

   // True when the size selector is legal for the access direction and the
   // low address bits are naturally aligned for that size.
   function automatic logic access_ok(input logic       is_store,
                                      input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
      logic legal;
      logic aligned;
      legal   = 1'b0;
      aligned = 1'b0;
      case (funct3)
         F3_B:    begin legal = 1'b1;      aligned = 1'b1;             end
         F3_H:    begin legal = 1'b1;      aligned = ~addr_lo[0];      end
         F3_W:    begin legal = 1'b1;      aligned = (addr_lo == 2'b00); end
         F3_BU:   begin legal = ~is_store; aligned = 1'b1;             end
         F3_HU:   begin legal = ~is_store; aligned = ~addr_lo[0];      end
         default: begin legal = 1'b0;      aligned = 1'b0;             end
      endcase
      return legal & aligned;
   endfunction

endpackage

// File: rtl/lsu_load_format.sv
// Combinational load-data formatter: picks the addressed byte/half out of the
// returned word and sign- or zero-extends it according to the size selector.
module lsu_load_format
   import core_pkg::*;
(
   input  logic [2:0]  funct3_in,
   input  logic [1:0]  byte_off_in,
   input  logic [31:0] rdata_in,
   output logic [31:0] value_out
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Lane selection and extension.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so
      // no path through the case statements can infer a latch.
      byte_sel  = rdata_in[7:0];
      half_sel  = byte_off_in[1] ? rdata_in[31:16] : rdata_in[15:0];
      value_out = rdata_in;
      case (byte_off_in)
         2'd0: byte_sel = rdata_in[7:0];
         2'd1: byte_sel = rdata_in[15:8];
         2'd2: byte_sel = rdata_in[23:16];
         2'd3: byte_sel = rdata_in[31:24];
         default: byte_sel = rdata_in[7:0];
      endcase
      case (funct3_in)
         F3_B:    value_out = {{24{byte_sel[7]}}, byte_sel};
         F3_H:    value_out = {{16{half_sel[15]}}, half_sel};
         F3_BU:   value_out = {24'd0, byte_sel};
         F3_HU:   value_out = {16'd0, half_sel};
         default: value_out = rdata_in;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: passes ALU results straight to writeback, runs loads
// and stores against a ready/rvalid data-memory port, and flags illegal or
// misaligned accesses with a one-cycle fault pulse.
module mem_stage
   import core_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        valid_in,
   input  logic [6:0]  opcode_in,
   input  logic [2:0]  funct3_in,
   input  logic [31:0] addr_in,
   input  logic [31:0] store_data_in,
   input  logic [31:0] result_in,
   input  logic [4:0]  rd_in,
   input  logic        rd_write_in,
   output logic        stall_out,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ready_in,
   input  logic        dmem_rvalid_in,
   input  logic [31:0] dmem_rdata_in,
   output logic        wb_valid_out,
   output logic [4:0]  wb_rd_out,
   output logic [31:0] wb_value_out,
   output logic        fault_out
);

   mem_state_e  state_q, state_d;
   logic        is_store_q, is_store_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [1:0]  off_q, off_d;
   logic [29:0] waddr_q, waddr_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;
   logic [4:0]  rd_q, rd_d;
   logic        wb_valid_q, wb_valid_d;
   logic [4:0]  wb_rd_q, wb_rd_d;
   logic [31:0] wb_value_q, wb_value_d;
   logic        fault_q, fault_d;

   logic        is_mem;
   logic        is_store_in;
   logic        acc_ok;
   logic [3:0]  st_be;
   logic [31:0] st_wdata;
   logic [31:0] load_value;
   logic        in_req;

   assign is_store_in = (opcode_in == OPC_STORE);
   assign is_mem      = (opcode_in == OPC_LOAD) || is_store_in;
   assign acc_ok      = access_ok(is_store_in, funct3_in, addr_in[1:0]);

   // Byte-lane enables and lane-replicated write data for the incoming access.
   always_comb begin
      st_be    = 4'b1111;
      st_wdata = '0;
      if (is_store_in) begin
         st_wdata = store_data_in;
         case (funct3_in[1:0])
            2'b00: begin
               st_be    = 4'b0001 << addr_in[1:0];
               st_wdata = {4{store_data_in[7:0]}};
            end
            2'b01: begin
               st_be    = 4'b0011 << {addr_in[1], 1'b0};
               st_wdata = {2{store_data_in[15:0]}};
            end
            default: ;
         endcase
      end
   end

   lsu_load_format u_load_format (
      .funct3_in   (funct3_q),
      .byte_off_in (off_q),
      .rdata_in    (dmem_rdata_in),
      .value_out   (load_value)
   );

   // Next-state, capture and writeback/fault pulse logic.
   always_comb begin
      state_d    = state_q;
      is_store_d = is_store_q;
      funct3_d   = funct3_q;
      off_d      = off_q;
      waddr_d    = waddr_q;
      be_d       = be_q;
      wdata_d    = wdata_q;
      rd_d       = rd_q;
      wb_valid_d = 1'b0;
      wb_rd_d    = wb_rd_q;
      wb_value_d = wb_value_q;
      fault_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (valid_in) begin
               if (!is_mem) begin
                  wb_valid_d = rd_write_in;
                  wb_rd_d    = rd_in;
                  wb_value_d = result_in;
               end else if (acc_ok) begin
                  is_store_d = is_store_in;
                  funct3_d   = funct3_in;
                  off_d      = addr_in[1:0];
                  waddr_d    = addr_in[31:2];
                  be_d       = st_be;
                  wdata_d    = st_wdata;
                  rd_d       = rd_in;
                  state_d    = ST_REQ;
               end else begin
                  fault_d = 1'b1;
               end
            end
         end
         ST_REQ: begin
            if (dmem_ready_in) begin
               if (is_store_q) begin
                  state_d = ST_IDLE;
               end else if (dmem_rvalid_in) begin
                  wb_valid_d = (rd_q != 5'd0);
                  if (rd_q != 5'd0) begin
                     wb_rd_d    = rd_q;
                     wb_value_d = load_value;
                  end
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (dmem_rvalid_in) begin
               wb_valid_d = (rd_q != 5'd0);
               if (rd_q != 5'd0) begin
                  wb_rd_d    = rd_q;
                  wb_value_d = load_value;
               end
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset discards any access in flight.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (reset) begin
         state_q    <= ST_IDLE;
         is_store_q <= 1'b0;
         funct3_q   <= '0;
         off_q      <= '0;
         waddr_q    <= '0;
         be_q       <= '0;
         wdata_q    <= '0;
         rd_q       <= '0;
         wb_valid_q <= 1'b0;
         wb_rd_q    <= '0;
         wb_value_q <= '0;
         fault_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         is_store_q <= is_store_d;
         funct3_q   <= funct3_d;
         off_q      <= off_d;
         waddr_q    <= waddr_d;
         be_q       <= be_d;
         wdata_q    <= wdata_d;
         rd_q       <= rd_d;
         wb_valid_q <= wb_valid_d;
         wb_rd_q    <= wb_rd_d;
         wb_value_q <= wb_value_d;
         fault_q    <= fault_d;
      end
   end

   // Memory port is driven only while requesting, so reset drops it at once.
   assign in_req     = (state_q == ST_REQ);
   assign stall_out  = (state_q != ST_IDLE);
   assign dmem_req   = in_req;
   assign dmem_we    = in_req & is_store_q;
   assign dmem_addr  = in_req ? {waddr_q, 2'b00} : 32'd0;
   assign dmem_be    = in_req ? be_q : 4'b0000;
   assign dmem_wdata = in_req ? wdata_q : 32'd0;

   assign wb_valid_out = wb_valid_q;
   assign wb_rd_out    = wb_rd_q;
   assign wb_value_out = wb_value_q;
   assign fault_out    = fault_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed load/store/fault/reset scenarios plus a sweep
// of load sizes and offsets; writebacks are matched against a scoreboard.
module tb_mem_stage;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_ALU   = 7'b0110011;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] value;
   } wb_exp_t;

   logic        clk;
   logic        reset;
   logic        valid_in;
   logic [6:0]  opcode_in;
   logic [2:0]  funct3_in;
   logic [31:0] addr_in;
   logic [31:0] store_data_in;
   logic [31:0] result_in;
   logic [4:0]  rd_in;
   logic        rd_write_in;
   logic        stall_out;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_wdata;
   logic        dmem_ready_in;
   logic        dmem_rvalid_in;
   logic [31:0] dmem_rdata_in;
   logic        wb_valid_out;
   logic [4:0]  wb_rd_out;
   logic [31:0] wb_value_out;
   logic        fault_out;

   int      n_checks = 0;
   int      n_pass   = 0;
   wb_exp_t sb_q[$];

   mem_stage dut (
      .clk            (clk),
      .reset          (reset),
      .valid_in       (valid_in),
      .opcode_in      (opcode_in),
      .funct3_in      (funct3_in),
      .addr_in        (addr_in),
      .store_data_in  (store_data_in),
      .result_in      (result_in),
      .rd_in          (rd_in),
      .rd_write_in    (rd_write_in),
      .stall_out      (stall_out),
      .dmem_req       (dmem_req),
      .dmem_we        (dmem_we),
      .dmem_addr      (dmem_addr),
      .dmem_be        (dmem_be),
      .dmem_wdata     (dmem_wdata),
      .dmem_ready_in  (dmem_ready_in),
      .dmem_rvalid_in (dmem_rvalid_in),
      .dmem_rdata_in  (dmem_rdata_in),
      .wb_valid_out   (wb_valid_out),
      .wb_rd_out      (wb_rd_out),
      .wb_value_out   (wb_value_out),
      .fault_out      (fault_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // Reference load formatting: shift the word down, then extend.
   function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] w);
      logic [31:0] sh;
      sh = w >> (8 * off);
      case (f3)
         3'b000:  return {{24{sh[7]}}, sh[7:0]};
         3'b001:  return {{16{sh[15]}}, sh[15:0]};
         3'b100:  return {24'd0, sh[7:0]};
         3'b101:  return {16'd0, sh[15:0]};
         default: return w;
      endcase
   endfunction

   // Every writeback pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!reset && wb_valid_out) begin
         if (sb_q.size() == 0) begin
            check("wb_unexpected", 32'd1, 32'd0);
         end else begin
            wb_exp_t e;
            e = sb_q.pop_front();
            check("wb_rd", wb_rd_out, e.rd);
            check("wb_value", wb_value_out, e.value);
         end
      end
   end

   task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] sdata, input logic [31:0] res,
                        input logic [4:0] rd, input logic rdw);
      @(negedge clk);
      valid_in      = 1'b1;
      opcode_in     = op;
      funct3_in     = f3;
      addr_in       = addr;
      store_data_in = sdata;
      result_in     = res;
      rd_in         = rd;
      rd_write_in   = rdw;
   endtask

   // Run one memory access: REQ lasts rdy_dly+1 cycles, read data arrives
   // rv_extra cycles after acceptance. Spurious rvalid is driven while the
   // request is not yet accepted. With hold_valid an unrelated ALU op is
   // presented during the stall and must be ignored.
   task automatic do_mem(input string tag, input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sdata, input logic [4:0] rd,
                         input int rdy_dly, input int rv_extra, input logic [31:0] rdata,
                         input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                         input bit hold_valid, output int stall_cycles);
      bit done;
      done = 1'b0;
      stall_cycles = 0;
      issue(op, f3, addr, sdata, 32'd0, rd, 1'b1);
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(negedge clk);
         if (hold_valid) begin
            opcode_in = OP_ALU; result_in = 32'h0BAD_0BAD; rd_in = 5'd7; rd_write_in = 1'b1;
         end else begin
            valid_in = 1'b0;
         end
         if (!stall_out) begin
            done = 1'b1;
            break;
         end
         stall_cycles++;
         if (cyc <= rdy_dly) begin
            check({tag, "_req"}, dmem_req, 32'd1);
            check({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
            check({tag, "_be"}, dmem_be, exp_be);
            check({tag, "_we"}, dmem_we, (op == OP_STORE));
            if (op == OP_STORE) check({tag, "_wdata"}, dmem_wdata, exp_wdata);
         end else begin
            check({tag, "_wait_req"}, dmem_req, 32'd0);
         end
         dmem_ready_in  = (cyc == rdy_dly);
         dmem_rvalid_in = (cyc < rdy_dly) || (cyc == rdy_dly + rv_extra);
         dmem_rdata_in  = (cyc == rdy_dly + rv_extra) ? rdata : 32'hDEAD_BEEF;
      end
      valid_in       = 1'b0;
      dmem_ready_in  = 1'b0;
      dmem_rvalid_in = 1'b0;
      if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic do_fault(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic [31:0] addr);
      issue(op, f3, addr, 32'h5555_AAAA, 32'd0, 5'd4, 1'b1);
      #1 check({tag, "_req0"}, dmem_req, 32'd0);
      @(negedge clk);
      valid_in = 1'b0;
      check({tag, "_fault"}, fault_out, 32'd1);
      check({tag, "_req1"}, dmem_req, 32'd0);
      check({tag, "_stall"}, stall_out, 32'd0);
      check({tag, "_wbv"}, wb_valid_out, 32'd0);
      @(negedge clk);
      check({tag, "_pulse"}, fault_out, 32'd0);
   endtask

   initial begin
      int      sc;
      wb_exp_t e;
      logic [31:0] w;
      logic [4:0]  r;

      reset = 1'b1; valid_in = 1'b0; opcode_in = '0; funct3_in = '0; addr_in = '0;
      store_data_in = '0; result_in = '0; rd_in = '0; rd_write_in = 1'b0;
      dmem_ready_in = 1'b0; dmem_rvalid_in = 1'b0; dmem_rdata_in = '0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_stall", stall_out, 32'd0);
      check("rst_req", dmem_req, 32'd0);
      check("rst_we", dmem_we, 32'd0);
      check("rst_addr", dmem_addr, 32'd0);
      check("rst_be", dmem_be, 32'd0);
      check("rst_wdata", dmem_wdata, 32'd0);
      check("rst_wbv", wb_valid_out, 32'd0);
      check("rst_wbrd", wb_rd_out, 32'd0);
      check("rst_wbval", wb_value_out, 32'd0);
      check("rst_fault", fault_out, 32'd0);
      reset = 1'b0;

      // ALU pass-through
      e.rd = 5'd5; e.value = 32'h0000_0042; sb_q.push_back(e);
      issue(OP_ALU, 3'b000, 32'h0, 32'h0, 32'h0000_0042, 5'd5, 1'b1);
      #1 check("add_stall0", stall_out, 32'd0);
      @(negedge clk);
      valid_in = 1'b0;
      check("add_wbv", wb_valid_out, 32'd1);
      check("add_stall1", stall_out, 32'd0);
      @(negedge clk);
      check("add_pulse", wb_valid_out, 32'd0);

      // LB with delayed ready and later rvalid, upstream presenting another op
      e.rd = 5'd10; e.value = 32'hFFFF_FF80; sb_q.push_back(e);
      do_mem("lb", OP_LOAD, 3'b000, 32'h0000_1003, 32'h0, 5'd10, 2, 1, 32'h80FF_0000,
             4'b1111, 32'h0, 1'b1, sc);
      check("lb_stall_cycles", sc, 32'd4);
      @(negedge clk);
      check("lb_pulse", wb_valid_out, 32'd0);

      // SH, ready immediately
      do_mem("sh", OP_STORE, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 5'd0, 0, 0, 32'h0,
             4'b1100, 32'hABCD_ABCD, 1'b0, sc);
      check("sh_stall_cycles", sc, 32'd1);
      check("sh_nowb", wb_valid_out, 32'd0);

      // SB odd byte lane, SW full word
      do_mem("sb", OP_STORE, 3'b000, 32'h0000_6001, 32'hCAFE_125A, 5'd0, 1, 0, 32'h0,
             4'b0010, 32'h5A5A_5A5A, 1'b0, sc);
      check("sb_nowb", wb_valid_out, 32'd0);
      do_mem("sw", OP_STORE, 3'b010, 32'h0000_6004, 32'h8765_4321, 5'd0, 0, 0, 32'h0,
             4'b1111, 32'h8765_4321, 1'b0, sc);

      // Faults: misaligned and unsupported encodings
      do_fault("lw_mis", OP_LOAD, 3'b010, 32'h0000_3001);
      do_fault("lh_mis", OP_LOAD, 3'b001, 32'h0000_3003);
      do_fault("sw_mis", OP_STORE, 3'b010, 32'h0000_3002);
      do_fault("sbu_ill", OP_STORE, 3'b100, 32'h0000_3000);
      do_fault("ld_ill", OP_LOAD, 3'b011, 32'h0000_3000);

      // LHU with ready and rvalid together
      e.rd = 5'd12; e.value = 32'h0000_F00D; sb_q.push_back(e);
      do_mem("lhu", OP_LOAD, 3'b101, 32'h0000_4000, 32'h0, 5'd12, 0, 0, 32'h0000_F00D,
             4'b1111, 32'h0, 1'b0, sc);
      check("lhu_stall_cycles", sc, 32'd1);

      // Load to x0 still accesses memory but writes nothing back
      do_mem("lw_x0", OP_LOAD, 3'b010, 32'h0000_7000, 32'h0, 5'd0, 1, 1, 32'h1357_9BDF,
             4'b1111, 32'h0, 1'b0, sc);
      check("lw_x0_stall_cycles", sc, 32'd3);
      check("lw_x0_nowb", wb_valid_out, 32'd0);

      // Sweep of load sizes and offsets against the reference model
      for (int f = 0; f < 5; f++) begin
         logic [2:0] f3;
         int step;
         f3   = (f == 0) ? 3'b000 : (f == 1) ? 3'b001 : (f == 2) ? 3'b010 :
                (f == 3) ? 3'b100 : 3'b101;
         step = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
         for (int off = 0; off < 4; off += step) begin
            logic [1:0] o;
            o = 2'(off);
            w = $urandom();
            r = 5'($urandom_range(31, 1));
            e.rd = r; e.value = load_model(f3, o, w); sb_q.push_back(e);
            do_mem("sweep", OP_LOAD, f3, 32'h0000_8000 + 32'(off), 32'h0, r,
                   int'($urandom_range(2, 0)), int'($urandom_range(2, 0)), w,
                   4'b1111, 32'h0, 1'b0, sc);
         end
      end

      // Reset while requesting drops the request immediately
      issue(OP_LOAD, 3'b010, 32'h0000_5000, 32'h0, 32'h0, 5'd9, 1'b1);
      @(negedge clk);
      valid_in = 1'b0;
      check("rstreq_req", dmem_req, 32'd1);
      #2 reset = 1'b1;
      #1 check("rstreq_req_drop", dmem_req, 32'd0);
      check("rstreq_stall_drop", stall_out, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Reset while waiting for read data; later rvalid is ignored
      issue(OP_LOAD, 3'b010, 32'h0000_5000, 32'h0, 32'h0, 5'd9, 1'b1);
      @(negedge clk);
      valid_in = 1'b0;
      dmem_ready_in = 1'b1;
      @(negedge clk);
      dmem_ready_in = 1'b0;
      check("rstwait_req", dmem_req, 32'd0);
      check("rstwait_stall", stall_out, 32'd1);
      #2 reset = 1'b1;
      #1 check("rstwait_stall_drop", stall_out, 32'd0);
      check("rstwait_req_drop", dmem_req, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      dmem_rvalid_in = 1'b1;
      dmem_rdata_in  = 32'h1111_2222;
      @(negedge clk);
      dmem_rvalid_in = 1'b0;
      check("rstwait_nowb", wb_valid_out, 32'd0);
      check("rstwait_idle", stall_out, 32'd0);
      @(negedge clk);
      check("rstwait_nowb2", wb_valid_out, 32'd0);

      check("sb_empty", sb_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 reset  in  1  asynchronous, active-high; forces reset state immediately.
REQ-003 valid_in  in  1  execute-stage outputs valid this cycle.
REQ-004 opcode_in  in  7  instruction opcode (0000011 load, 0100011 store, other = non-memory).
REQ-005 funct3_in  in  3  access size/sign selector.
REQ-006 addr_in  in  32  effective address from execute ALU.
REQ-007 store_data_in  in  32  rs2 value for stores.
REQ-008 result_in  in  32  ALU result for non-memory instructions.
REQ-009 rd_in / rd_write_in  in  5 / 1  destination register and write request.
REQ-010 stall_out  out  1  upstream must hold its outputs while high.
REQ-011 dmem_req / dmem_we  out  1 / 1  memory request, write enable.
REQ-012 dmem_addr / dmem_be / dmem_wdata  out  32 / 4 / 32  word-aligned address, byte enables, write data.
REQ-013 dmem_ready_in  in  1  memory accepts request this cycle.
REQ-014 dmem_rvalid_in / dmem_rdata_in  in  1 / 32  read data valid, read word.
REQ-015 wb_valid_out / wb_rd_out / wb_value_out  out  1 / 5 / 32  registered writeback to register file.
REQ-016 fault_out  out  1  one-cycle pulse: misaligned or unsupported access.

Function
REQ-017 FSM states SHALL be IDLE, REQ, WAIT; stall_out = (state != IDLE), combinational.
REQ-018 IDLE, valid_in, non-memory opcode: next cycle wb_valid_out=rd_write_in, wb_rd_out=rd_in, wb_value_out=result_in; state stays IDLE.
REQ-019 IDLE, valid_in, load/store, legal and aligned: capture opcode, funct3, addr, data, rd; go to REQ.
REQ-020 Legal loads funct3 000/001/010/100/101; legal stores 000/001/010; anything else SHALL pulse fault_out next cycle, no request, no writeback, stay IDLE.
REQ-021 Misaligned (half: addr[0]=1; word: addr[1:0]!=0) SHALL be handled identically to REQ-020.
REQ-022 REQ: dmem_req=1 with stable addr/be/wdata/we until dmem_ready_in; dmem_addr = {addr[31:2],2'b00}.
REQ-023 Store byte: be=0001<<addr[1:0], wdata=byte replicated x4; half: be=0011<<{addr[1],1'b0}, wdata=half replicated x2; word: be=1111.
REQ-024 Loads: dmem_we=0, dmem_be=1111.
REQ-025 REQ with ready, store: go IDLE; no writeback pulse.
REQ-026 REQ with ready, load: if dmem_rvalid_in same cycle complete as REQ-028, else go WAIT.
REQ-027 WAIT: hold until dmem_rvalid_in; dmem_req=0.
REQ-028 Load completion: next cycle wb_valid_out=1, wb_rd_out=captured rd, wb_value_out = byte/half selected by addr[1:0], sign-extended (000/001) or zero-extended (100/101), word unchanged (010); go IDLE.
REQ-029 wb_valid_out and fault_out SHALL be single-cycle pulses; wb_value_out holds last value otherwise.
REQ-030 dmem_rvalid_in in IDLE or REQ-without-ready SHALL be ignored.
REQ-031 valid_in while state != IDLE SHALL be ignored (upstream holds).
REQ-032 Load with rd_in=0 SHALL perform the access and drive wb_valid_out=0.

Reset
REQ-033 Reset SHALL force IDLE and drive stall_out, dmem_req, dmem_we, wb_valid_out, fault_out to 0; dmem_addr, dmem_wdata, wb_value_out to 0; dmem_be to 0000; wb_rd_out to 0.
REQ-034 Reset mid-transaction SHALL drop dmem_req in the same cycle and discard the pending access; no writeback follows.

Structure
REQ-035 Opcode constants, funct3 constants and the FSM state enum SHALL live in shared package core_pkg.
REQ-036 Load extraction/extension SHALL be a combinational sub-module lsu_load_format.

Verification
REQ-037 ADD result 0x0000_0042, rd=5, rd_write=1 -> next cycle wb_valid_out=1, wb_rd_out=5, wb_value_out=0x42, stall_out never high.
REQ-038 LB addr 0x1003, ready after 2 cycles, rvalid 1 cycle later with rdata 0x80FF_0000 -> dmem_addr 0x1000, wb_value_out=0xFFFF_FF80, stall_out high 4 cycles.
REQ-039 SH addr 0x2002, data 0x1234_ABCD, ready immediately -> be=1100, wdata=0xABCD_ABCD, we=1, no wb pulse.
REQ-040 LW addr 0x3001 -> fault_out pulse, dmem_req never asserted, wb_valid_out=0.
REQ-041 LHU addr 0x4000, ready and rvalid same cycle, rdata 0x0000_F00D -> wb_value_out=0x0000_F00D one cycle later.
REQ-042 Reset asserted while in WAIT -> dmem_req/stall_out 0 immediately; later rvalid ignored, no wb pulse.
